// File: rtl/vga_timing_tx_if.sv
// Game-logic / connector bundle of the VGA timing transmitter.
// master = timing source (vga_timing_tx), slave = game logic / display consumer.
interface vga_timing_tx_if;
    logic [29:0] rgb_in;
    logic        active_area;
    logic [9:0]  screen_x;
    logic [9:0]  screen_y;
    logic        pix_en;
    logic        frame_start;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        vga_sync_n;
    logic [9:0]  vga_r;
    logic [9:0]  vga_g;
    logic [9:0]  vga_b;

    modport master (
        input  rgb_in,
        output active_area, screen_x, screen_y, pix_en, frame_start,
        output vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b
    );

    modport slave (
        output rgb_in,
        input  active_area, screen_x, screen_y, pix_en, frame_start,
        input  vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_timing_tx.sv
// 640x480@60 VGA raster generator with a one-pixel registered RGB/sync output stage.
// Optional VGA_CLK_DIV2_EN: pixel strobe on every second clk (50 MHz clk -> 25 MHz pixels).
module vga_timing_tx #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_tx_if.master  bus
);

    // Both totals must fit in the 10-bit counters (<= 1024).
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       pix_en;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       active;
    logic       hs_raw, vs_raw;

    logic [9:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;

`ifdef VGA_CLK_DIV2_EN
    logic tog_q, tog_d;

    always_comb begin
        tog_d = ~tog_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tog_q <= 1'b0;
        end else begin
            tog_q <= tog_d;
        end
    end

    assign pix_en = tog_q;
`else
    assign pix_en = 1'b1;
`endif

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_comb begin
        active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_raw = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_raw = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    // Output stage registers the pixel at the current counters, so syncs/blank are
    // delayed by the same single pixel as the RGB returned by the game logic.
    always_comb begin
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        if (pix_en) begin
            r_d       = active ? bus.rgb_in[29:20] : 10'd0;
            g_d       = active ? bus.rgb_in[19:10] : 10'd0;
            b_d       = active ? bus.rgb_in[9:0]   : 10'd0;
            hs_d      = hs_raw;
            vs_d      = vs_raw;
            blank_n_d = active;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            r_q       <= 10'd0;
            g_q       <= 10'd0;
            b_q       <= 10'd0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            blank_n_q <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
        end
    end

    // Gated by reset so the strobe stays low while held in reset with pix_en tied high.
    assign bus.frame_start = pix_en && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0) && !reset;

    assign bus.pix_en      = pix_en;
    assign bus.active_area = active;
    assign bus.screen_x    = h_cnt_q;
    assign bus.screen_y    = v_cnt_q;
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.vga_blank_n = blank_n_q;
    assign bus.vga_sync_n  = 1'b0;
    assign bus.vga_r       = r_q;
    assign bus.vga_g       = g_q;
    assign bus.vga_b       = b_q;

endmodule

// File: tb/tb_vga_timing_tx.sv
// Directed bench for vga_timing_tx; horizontal timing at defaults, a short frame
// (10 lines) keeps vertical/frame checks within a small cycle budget.
module tb_vga_timing_tx;

`ifdef VGA_CLK_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif
    localparam int V_ACT      = 6;
    localparam int V_FP       = 1;
    localparam int V_SYN      = 2;
    localparam int V_BP       = 1;
    localparam int V_TOT      = V_ACT + V_FP + V_SYN + V_BP;
    localparam int LINE_CLKS  = 800 * DIV;
    localparam int FRAME_CLKS = LINE_CLKS * V_TOT;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    vga_timing_tx_if bus_if ();

    vga_timing_tx #(
        .V_ACTIVE (V_ACT),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYN),
        .V_BP     (V_BP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Returns at a negedge sample where pix_en=1 at (x,y); y<0 matches any line.
    task automatic wait_pos(input int x, input int y, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus_if.pix_en && bus_if.screen_x == 10'(x) &&
                 (y < 0 || bus_if.screen_y == 10'(y))) && n < 2 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FRAME_CLKS) begin
            checks++; errors++;
            $display("FAIL %s: position (%0d,%0d) never reached", name, x, y);
        end
    endtask

    task automatic next_pix(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_if.pix_en && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.pix_en) begin
            checks++; errors++;
            $display("FAIL %s: no pix_en strobe", name);
        end
    endtask

    // Release at a negedge and expect frame_start on the first pix_en, one clk wide.
    task automatic release_check(input string name);
        int n;
        reset = 1'b0;
        #1;
        n = 0;
        while (!bus_if.pix_en && n < 4) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus_if.frame_start !== 1'b1 || bus_if.screen_x !== 10'd0 ||
            bus_if.screen_y !== 10'd0) begin
            errors++;
            $display("FAIL %s_first_frame_start: got fs=%b x=%0d y=%0d, need fs=1 x=0 y=0",
                     name, bus_if.frame_start, bus_if.screen_x, bus_if.screen_y);
        end
        @(negedge clk);
        checks++;
        if (bus_if.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL %s_fs_width: got %b, need 0", name, bus_if.frame_start);
        end
    endtask

    task automatic test_reset();
        bus_if.rgb_in = 30'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_if.screen_x !== 10'd0 || bus_if.screen_y !== 10'd0) begin
            errors++;
            $display("FAIL reset_counters: got x=%0d y=%0d, need 0,0",
                     bus_if.screen_x, bus_if.screen_y);
        end
        checks++;
        if (bus_if.vga_hs !== 1'b1 || bus_if.vga_vs !== 1'b1) begin
            errors++;
            $display("FAIL reset_syncs: got hs=%b vs=%b, need 1,1", bus_if.vga_hs, bus_if.vga_vs);
        end
        checks++;
        if (bus_if.vga_blank_n !== 1'b0 || bus_if.vga_sync_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_blank: got blank_n=%b sync_n=%b, need 0,0",
                     bus_if.vga_blank_n, bus_if.vga_sync_n);
        end
        checks++;
        if ({bus_if.vga_r, bus_if.vga_g, bus_if.vga_b} !== 30'd0) begin
            errors++;
            $display("FAIL reset_rgb: got %h, need 0", {bus_if.vga_r, bus_if.vga_g, bus_if.vga_b});
        end
        checks++;
        if (bus_if.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_start: got %b, need 0", bus_if.frame_start);
        end
        release_check("release");
    endtask

    task automatic test_midline_reset();
        bus_if.rgb_in = '1;
        wait_pos(300, 0, "midline_wait");
        checks++;
        if (bus_if.vga_r !== 10'h3FF || bus_if.vga_blank_n !== 1'b1) begin
            errors++;
            $display("FAIL midline_pre: got r=%h blank_n=%b, need 3ff,1",
                     bus_if.vga_r, bus_if.vga_blank_n);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus_if.screen_x !== 10'd0 || bus_if.vga_hs !== 1'b1 || bus_if.vga_vs !== 1'b1 ||
            bus_if.vga_blank_n !== 1'b0 || bus_if.vga_r !== 10'd0) begin
            errors++;
            $display("FAIL midline_async: got x=%0d hs=%b vs=%b blank_n=%b r=%h, need 0,1,1,0,0",
                     bus_if.screen_x, bus_if.vga_hs, bus_if.vga_vs, bus_if.vga_blank_n,
                     bus_if.vga_r);
        end
        @(negedge clk);
        bus_if.rgb_in = 30'd0;
        release_check("midline_release");
    endtask

    task automatic test_pix_en();
        logic exp;
        next_pix("pix_en_sync");
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            exp = (DIV == 1) ? 1'b1 : ((i % 2) == 0);
            checks++;
            if (bus_if.pix_en !== exp) begin
                errors++;
                $display("FAIL pix_en_pattern[%0d]: got %b, need %b", i, bus_if.pix_en, exp);
            end
        end
    endtask

    task automatic test_hsync();
        int lo;
        int hi;
        wait_pos(656, 0, "hs_wait");
        checks++;
        if (bus_if.vga_hs !== 1'b1) begin
            errors++;
            $display("FAIL hs_before: got %b, need 1", bus_if.vga_hs);
        end
        @(negedge clk);
        checks++;
        if (bus_if.vga_hs !== 1'b0) begin
            errors++;
            $display("FAIL hs_first_low: got %b, need 0", bus_if.vga_hs);
        end
        lo = 1;
        while (lo < 4000) begin
            @(negedge clk);
            if (bus_if.vga_hs !== 1'b0) break;
            lo++;
        end
        checks++;
        if (lo != 96 * DIV) begin
            errors++;
            $display("FAIL hs_width: got %0d clks, need %0d", lo, 96 * DIV);
        end
        hi = 1;
        while (hi < 4000) begin
            @(negedge clk);
            if (bus_if.vga_hs !== 1'b1) break;
            hi++;
        end
        checks++;
        if (lo + hi != LINE_CLKS) begin
            errors++;
            $display("FAIL line_period: got %0d clks, need %0d", lo + hi, LINE_CLKS);
        end
    endtask

    task automatic test_pipeline();
        wait_pos(10, 4, "pipe_wait_a");
        bus_if.rgb_in = 30'h3FF0_0000;
        @(negedge clk);
        checks++;
        if (bus_if.vga_r !== 10'h3FF || bus_if.vga_g !== 10'd0 || bus_if.vga_b !== 10'd0 ||
            bus_if.vga_blank_n !== 1'b1) begin
            errors++;
            $display("FAIL pipe_red: got r=%h g=%h b=%h blank_n=%b, need 3ff,0,0,1",
                     bus_if.vga_r, bus_if.vga_g, bus_if.vga_b, bus_if.vga_blank_n);
        end
`ifdef VGA_CLK_DIV2_EN
        bus_if.rgb_in = 30'd0;
        @(negedge clk);
        checks++;
        if (bus_if.vga_r !== 10'h3FF || bus_if.screen_x !== 10'd11) begin
            errors++;
            $display("FAIL pipe_hold: got r=%h x=%0d, need 3ff,11", bus_if.vga_r, bus_if.screen_x);
        end
`endif
        wait_pos(20, 4, "pipe_wait_b");
        bus_if.rgb_in = {10'h000, 10'h2AA, 10'h155};
        @(negedge clk);
        checks++;
        if (bus_if.vga_r !== 10'd0 || bus_if.vga_g !== 10'h2AA || bus_if.vga_b !== 10'h155) begin
            errors++;
            $display("FAIL pipe_gb: got r=%h g=%h b=%h, need 0,2aa,155",
                     bus_if.vga_r, bus_if.vga_g, bus_if.vga_b);
        end
        wait_pos(700, 4, "pipe_wait_c");
        bus_if.rgb_in = '1;
        @(negedge clk);
        checks++;
        if ({bus_if.vga_r, bus_if.vga_g, bus_if.vga_b} !== 30'd0 || bus_if.vga_blank_n !== 1'b0)
        begin
            errors++;
            $display("FAIL pipe_blanked: got rgb=%h blank_n=%b, need 0,0",
                     {bus_if.vga_r, bus_if.vga_g, bus_if.vga_b}, bus_if.vga_blank_n);
        end
    endtask

    task automatic test_active_edges();
        wait_pos(639, V_ACT - 1, "act_wait");
        checks++;
        if (bus_if.active_area !== 1'b1) begin
            errors++;
            $display("FAIL active_last: got %b, need 1", bus_if.active_area);
        end
        next_pix("act_step1");
        checks++;
        if (bus_if.screen_x !== 10'd640 || bus_if.active_area !== 1'b0 ||
            bus_if.vga_blank_n !== 1'b1) begin
            errors++;
            $display("FAIL active_h_edge: got x=%0d act=%b blank_n=%b, need 640,0,1",
                     bus_if.screen_x, bus_if.active_area, bus_if.vga_blank_n);
        end
        next_pix("act_step2");
        checks++;
        if (bus_if.vga_blank_n !== 1'b0) begin
            errors++;
            $display("FAIL blank_follow: got %b, need 0", bus_if.vga_blank_n);
        end
        wait_pos(0, V_ACT, "act_wait_v");
        checks++;
        if (bus_if.active_area !== 1'b0) begin
            errors++;
            $display("FAIL active_v_edge: got %b, need 0", bus_if.active_area);
        end
    endtask

    task automatic test_vsync();
        int lo;
        wait_pos(0, V_ACT + V_FP, "vs_wait");
        checks++;
        if (bus_if.vga_vs !== 1'b1) begin
            errors++;
            $display("FAIL vs_before: got %b, need 1", bus_if.vga_vs);
        end
        @(negedge clk);
        checks++;
        if (bus_if.vga_vs !== 1'b0) begin
            errors++;
            $display("FAIL vs_first_low: got %b, need 0", bus_if.vga_vs);
        end
        lo = 1;
        while (lo < 2 * FRAME_CLKS) begin
            @(negedge clk);
            if (bus_if.vga_vs !== 1'b0) break;
            lo++;
        end
        checks++;
        if (lo != V_SYN * LINE_CLKS) begin
            errors++;
            $display("FAIL vs_width: got %0d clks, need %0d", lo, V_SYN * LINE_CLKS);
        end
    endtask

    task automatic test_frame_period();
        int p;
        p = 0;
        while (bus_if.frame_start !== 1'b1 && p < 2 * FRAME_CLKS) begin
            @(negedge clk);
            p++;
        end
        @(negedge clk);
        checks++;
        if (bus_if.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL fs_width_run: got %b, need 0", bus_if.frame_start);
        end
        p = 1;
        while (bus_if.frame_start !== 1'b1 && p < 2 * FRAME_CLKS) begin
            @(negedge clk);
            p++;
        end
        checks++;
        if (p != FRAME_CLKS) begin
            errors++;
            $display("FAIL frame_period: got %0d clks, need %0d", p, FRAME_CLKS);
        end
    endtask

    initial begin
        test_reset();
        test_midline_reset();
        test_pix_en();
        test_hsync();
        test_pipeline();
        test_active_edges();
        test_vsync();
        test_frame_period();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
